// File: rtl/smi_frame_arbiter_x2.sv
// smi_frame_arbiter_x2: two-requester SMI frame arbiter with a registered output buffer.
// Optional build macro SMI_ARB_FIXED_PRIORITY_EN selects fixed A-first priority instead of round-robin.
module smi_frame_arbiter_x2 #(
   parameter int FlitWidth = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   smiInAReady,
   input  logic [7:0]             smiInAEofc,
   input  logic [FlitWidth*8-1:0] smiInAData,
   output logic                   smiInAStop,
   input  logic                   smiInBReady,
   input  logic [7:0]             smiInBEofc,
   input  logic [FlitWidth*8-1:0] smiInBData,
   output logic                   smiInBStop,
   output logic                   smiOutReady,
   output logic [7:0]             smiOutEofc,
   output logic [FlitWidth*8-1:0] smiOutData,
   input  logic                   smiOutStop
);

   typedef enum logic [1:0] {
      Idle = 2'd0,
      FwdA = 2'd1,
      FwdB = 2'd2
   } stateT;

   stateT state;
   stateT stateNext;

   logic xferA;
   logic xferB;
   logic finalA;
   logic finalB;

   assign xferA  = smiInAReady & ~smiInAStop;
   assign xferB  = smiInBReady & ~smiInBStop;
   assign finalA = |smiInAEofc;
   assign finalB = |smiInBEofc;

   // State register: the grant only changes at frame boundaries.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= Idle;
      end else begin
         state <= stateNext;
      end
   end

`ifdef SMI_ARB_FIXED_PRIORITY_EN
   // Next-state: A always wins an idle arbitration, B only when A is quiet.
   always_comb begin
      stateNext = state;
      unique case (state)
         Idle: begin
            if (smiInAReady) begin
               stateNext = FwdA;
            end else if (smiInBReady) begin
               stateNext = FwdB;
            end
         end
         FwdA: if (xferA && finalA) stateNext = Idle;
         FwdB: if (xferB && finalB) stateNext = Idle;
         default: stateNext = Idle;
      endcase
   end
`else
   logic lastGrantB;

   // Remember which port finished the most recent frame; B at reset so A wins first tie.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lastGrantB <= 1'b1;
      end else if (state == FwdA && xferA && finalA) begin
         lastGrantB <= 1'b0;
      end else if (state == FwdB && xferB && finalB) begin
         lastGrantB <= 1'b1;
      end
   end

   // Next-state: round-robin per frame, ties go to the port not granted last.
   always_comb begin
      stateNext = state;
      unique case (state)
         Idle: begin
            if (smiInAReady && smiInBReady) begin
               stateNext = lastGrantB ? FwdA : FwdB;
            end else if (smiInAReady) begin
               stateNext = FwdA;
            end else if (smiInBReady) begin
               stateNext = FwdB;
            end
         end
         FwdA: if (xferA && finalA) stateNext = Idle;
         FwdB: if (xferB && finalB) stateNext = Idle;
         default: stateNext = Idle;
      endcase
   end
`endif

   // Outputs: only the granted port may move, and only when the buffer can take a flit.
   always_comb begin
      smiInAStop = 1'b1;
      smiInBStop = 1'b1;
      unique case (state)
         FwdA: smiInAStop = smiOutReady & smiOutStop;
         FwdB: smiInBStop = smiOutReady & smiOutStop;
         default: ;
      endcase
   end

   // Output buffer: load on any granted transfer, drain when consumed without a refill.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         smiOutReady <= 1'b0;
         smiOutEofc  <= '0;
         smiOutData  <= '0;
      end else if (xferA) begin
         smiOutReady <= 1'b1;
         smiOutEofc  <= smiInAEofc;
         smiOutData  <= smiInAData;
      end else if (xferB) begin
         smiOutReady <= 1'b1;
         smiOutEofc  <= smiInBEofc;
         smiOutData  <= smiInBData;
      end else if (!smiOutStop) begin
         smiOutReady <= 1'b0;
      end
   end

endmodule

// File: tb/tb_smi_frame_arbiter_x2.sv
// tb_smi_frame_arbiter_x2: directed timing steps plus a randomized frame scoreboard
// for smi_frame_arbiter_x2 (honours SMI_ARB_FIXED_PRIORITY_EN when defined).
module tb_smi_frame_arbiter_x2;

   logic        clk;
   logic        rstn;
   logic        aReady;
   logic [7:0]  aEofc;
   logic [31:0] aData;
   logic        aStop;
   logic        bReady;
   logic [7:0]  bEofc;
   logic [31:0] bData;
   logic        bStop;
   logic        oReady;
   logic [7:0]  oEofc;
   logic [31:0] oData;
   logic        oStop;

   int nTests;
   int nFail;

   logic [39:0] aQ[$];
   logic [39:0] bQ[$];
   logic [39:0] expQ[$];
   int          aLen[6];
   int          bLen[6];
   int          aIdx;
   int          bIdx;
   int          ia;
   int          ib;
   int          len;
   bit          aPres;
   bit          bPres;
   bit          aMid;
   bit          bMid;
   logic [7:0]  e;
   logic [39:0] got;
   logic [39:0] want;

   smi_frame_arbiter_x2 #(.FlitWidth(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .smiInAReady (aReady),
      .smiInAEofc  (aEofc),
      .smiInAData  (aData),
      .smiInAStop  (aStop),
      .smiInBReady (bReady),
      .smiInBEofc  (bEofc),
      .smiInBData  (bData),
      .smiInBStop  (bStop),
      .smiOutReady (oReady),
      .smiOutEofc  (oEofc),
      .smiOutData  (oData),
      .smiOutStop  (oStop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic driveA(input logic r, input logic [7:0] ec, input logic [31:0] d);
      aReady = r;
      aEofc  = ec;
      aData  = d;
   endtask

   task automatic driveB(input logic r, input logic [7:0] ec, input logic [31:0] d);
      bReady = r;
      bEofc  = ec;
      bData  = d;
   endtask

   initial begin
      nTests = 0;
      nFail  = 0;
      rstn   = 1'b0;
      oStop  = 1'b0;
      driveA(0, 0, 0);
      driveB(0, 0, 0);

      // reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst oReady", oReady, 0);
      chk("rst oEofc", oEofc, 0);
      chk("rst oData", oData, 0);
      chk("rst aStop", aStop, 1);
      chk("rst bStop", bStop, 1);
      rstn = 1'b1;

      // A only, 3-flit frame, first flit 2 cycles after Ready
      @(negedge clk);
      driveA(1, 0, 32'hD000_0000);
      #1 chk("t2 idle aStop", aStop, 1);
      @(negedge clk);
      chk("t2 bubble oReady", oReady, 0);
      chk("t2 grant aStop", aStop, 0);
      @(negedge clk);
      chk("t2 D0", {oReady, oEofc, oData}, {1'b1, 8'd0, 32'hD000_0000});
      driveA(1, 0, 32'hD000_0001);
      @(negedge clk);
      chk("t2 D1", {oReady, oEofc, oData}, {1'b1, 8'd0, 32'hD000_0001});
      driveA(1, 4, 32'hD000_0002);
      @(negedge clk);
      chk("t2 D2", {oReady, oEofc, oData}, {1'b1, 8'd4, 32'hD000_0002});
      driveA(0, 0, 0);
      #1 chk("t2 back idle", aStop, 1);
      @(negedge clk);
      chk("t2 drained", oReady, 0);

      // back-pressure for 4 cycles mid-frame
      @(negedge clk);
      driveA(1, 0, 32'hE000_0000);
      @(negedge clk);
      @(negedge clk);
      chk("t4 E0", {oReady, oEofc, oData}, {1'b1, 8'd0, 32'hE000_0000});
      driveA(1, 0, 32'hE000_0001);
      oStop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4 held", {oReady, oEofc, oData}, {1'b1, 8'd0, 32'hE000_0000});
         chk("t4 aStop", aStop, 1);
      end
      oStop = 1'b0;
      @(negedge clk);
      chk("t4 E1", {oReady, oEofc, oData}, {1'b1, 8'd0, 32'hE000_0001});
      driveA(1, 1, 32'hE000_0002);
      @(negedge clk);
      chk("t4 E2", {oReady, oEofc, oData}, {1'b1, 8'd1, 32'hE000_0002});
      driveA(0, 0, 0);
      @(negedge clk);
      chk("t4 drained", oReady, 0);

      // no interleave while the A frame stalls
      @(negedge clk);
      driveA(1, 0, 32'hA500_0000);
      @(negedge clk);
      driveB(1, 0, 32'hB500_0000);
      @(negedge clk);
      chk("t5 A0", {oReady, oEofc, oData}, {1'b1, 8'd0, 32'hA500_0000});
      driveA(0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5 bStop", bStop, 1);
         chk("t5 no out", oReady, 0);
      end
      driveA(1, 2, 32'hA500_0001);
      @(negedge clk);
      chk("t5 A1", {oReady, oEofc, oData}, {1'b1, 8'd2, 32'hA500_0001});
      chk("t5 bStop idle", bStop, 1);
      driveA(0, 0, 0);
      @(negedge clk);
      chk("t5 B grant", bStop, 0);
      @(negedge clk);
      chk("t5 B0", {oReady, oEofc, oData}, {1'b1, 8'd0, 32'hB500_0000});
      driveB(1, 3, 32'hB500_0001);
      @(negedge clk);
      chk("t5 B1", {oReady, oEofc, oData}, {1'b1, 8'd3, 32'hB500_0001});
      driveB(0, 0, 0);
      @(negedge clk);
      chk("t5 drained", oReady, 0);

      // asynchronous reset mid-frame, checked between clock edges
      @(negedge clk);
      driveA(1, 0, 32'h1234_5678);
      @(negedge clk);
      @(negedge clk);
      chk("t1 pre full", oReady, 1);
      #2 rstn = 1'b0;
      #1;
      chk("t1 oReady", oReady, 0);
      chk("t1 oEofc", oEofc, 0);
      chk("t1 oData", oData, 0);
      chk("t1 aStop", aStop, 1);
      chk("t1 bStop", bStop, 1);
      driveA(0, 0, 0);

      // randomized frames from both ports, both always ready at frame start
      for (int f = 0; f < 6; f++) begin
         aLen[f] = int'($urandom_range(1, 4));
         for (int j = 0; j < aLen[f]; j++) begin
            e = (j == aLen[f] - 1) ? 8'($urandom_range(1, 255)) : 8'd0;
            aQ.push_back({e, 32'($urandom)});
         end
         bLen[f] = int'($urandom_range(1, 4));
         for (int j = 0; j < bLen[f]; j++) begin
            e = (j == bLen[f] - 1) ? 8'($urandom_range(1, 255)) : 8'd0;
            bQ.push_back({e, 32'($urandom)});
         end
      end
`ifdef SMI_ARB_FIXED_PRIORITY_EN
      foreach (aQ[k]) expQ.push_back(aQ[k]);
      foreach (bQ[k]) expQ.push_back(bQ[k]);
`else
      ia = 0;
      ib = 0;
      for (int f = 0; f < 6; f++) begin
         for (int j = 0; j < aLen[f]; j++) begin
            expQ.push_back(aQ[ia]);
            ia++;
         end
         for (int j = 0; j < bLen[f]; j++) begin
            expQ.push_back(bQ[ib]);
            ib++;
         end
      end
`endif
      aIdx  = 0;
      bIdx  = 0;
      aPres = 0;
      bPres = 0;
      aMid  = 0;
      bMid  = 0;
      for (int cyc = 0; cyc < 3000 && expQ.size() > 0; cyc++) begin
         @(negedge clk);
         if (cyc == 0) rstn = 1'b1;
         if (!aPres && aIdx < aQ.size()) begin
            if (!aMid || $urandom_range(0, 2) != 0) aPres = 1;
         end
         if (!bPres && bIdx < bQ.size()) begin
            if (!bMid || $urandom_range(0, 2) != 0) bPres = 1;
         end
         if (aPres) driveA(1, aQ[aIdx][39:32], aQ[aIdx][31:0]);
         else driveA(0, 0, 0);
         if (bPres) driveB(1, bQ[bIdx][39:32], bQ[bIdx][31:0]);
         else driveB(0, 0, 0);
         oStop = ($urandom_range(0, 3) == 0);
         #1;
         chk("rnd one grant", {1'b0, !aStop && !bStop}, 0);
         if (oReady && !oStop) begin
            got = {oEofc, oData};
            if (expQ.size() == 0) begin
               chk("rnd extra flit", got, 0);
            end else begin
               want = expQ.pop_front();
               chk("rnd flit", got, want);
            end
         end
         if (aReady && !aStop) begin
            aPres = 0;
            aMid  = (aEofc == 0);
            aIdx++;
         end
         if (bReady && !bStop) begin
            bPres = 0;
            bMid  = (bEofc == 0);
            bIdx++;
         end
      end
      chk("rnd all out", expQ.size(), 0);
      chk("rnd all A sent", aIdx, aQ.size());
      chk("rnd all B sent", bIdx, bQ.size());

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
